alu_mdu: RTL and testbench



---
 rtl/alu_mdu.sv | 256 +++++++++++++++++++++++++
 tb/tb_alu_mdu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: registered ALU stage plus an iterative multiply/divide unit with
// architectural HI/LO registers (MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO).
// Optional feature macro: ALU_MDU_DIV_EN builds the restoring divider. Without
// it DIV/DIVU complete in one cycle with result 0 and HI/LO left untouched.
module alu_mdu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       alu_op,
   input  logic [WIDTH-1:0] a_dat,
   input  logic [WIDTH-1:0] b_dat,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [4:0] OpAnd   = 5'd0;
   localparam logic [4:0] OpOr    = 5'd1;
   localparam logic [4:0] OpAdd   = 5'd2;
   localparam logic [4:0] OpSll   = 5'd3;
   localparam logic [4:0] OpSrl   = 5'd4;
   localparam logic [4:0] OpSra   = 5'd5;
   localparam logic [4:0] OpSub   = 5'd6;
   localparam logic [4:0] OpSlt   = 5'd7;
   localparam logic [4:0] OpNor   = 5'd8;
   localparam logic [4:0] OpXor   = 5'd9;
   localparam logic [4:0] OpAddu  = 5'd10;
   localparam logic [4:0] OpSltu  = 5'd11;
   localparam logic [4:0] OpSllv  = 5'd12;
   localparam logic [4:0] OpSrlv  = 5'd13;
   localparam logic [4:0] OpSubu  = 5'd14;
   localparam logic [4:0] OpSrav  = 5'd15;
   localparam logic [4:0] OpAddiu = 5'd16;
   localparam logic [4:0] OpXori  = 5'd17;
   localparam logic [4:0] OpLui   = 5'd18;
   localparam logic [4:0] OpSlti  = 5'd19;
   localparam logic [4:0] OpSltiu = 5'd20;
   localparam logic [4:0] OpMult  = 5'd22;
   localparam logic [4:0] OpMultu = 5'd23;
   localparam logic [4:0] OpDiv   = 5'd24;
   localparam logic [4:0] OpDivu  = 5'd25;
   localparam logic [4:0] OpMfhi  = 5'd26;
   localparam logic [4:0] OpMflo  = 5'd27;
   localparam logic [4:0] OpMthi  = 5'd28;
   localparam logic [4:0] OpMtlo  = 5'd29;

`ifdef ALU_MDU_DIV_EN
   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;
`else
   typedef enum logic [1:0] {StIdle, StMul, StFix} state_e;
`endif

   state_e               state_q;
   logic [SHW-1:0]       cnt_q;
   logic [2*WIDTH-1:0]   acc_q;      // mul: {upper, multiplier}; div: {rem, quo}
   logic [WIDTH-1:0]     opb_q;      // multiplicand or divisor magnitude
   logic                 neg_lo_q;   // negate product / quotient in StFix
`ifdef ALU_MDU_DIV_EN
   logic                 div_q;
   logic                 neg_hi_q;   // remainder takes the dividend's sign
   logic                 dz_q;
`endif
   logic [WIDTH-1:0]     result_q, hi_q, lo_q;
   logic                 zero_q, ovf_q, out_valid_q;

   logic [SHW-1:0]       shamt;
   logic [WIDTH-1:0]     sum, diff;
   logic                 slt_s, slt_u;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_ovf;

   assign shamt = a_dat[SHW-1:0];
   assign sum   = a_dat + b_dat;
   assign diff  = a_dat - b_dat;
   assign slt_s = $signed(a_dat) < $signed(b_dat);
   assign slt_u = a_dat < b_dat;

   // Single-cycle ALU result and signed overflow for ADD/SUB only
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (alu_op)
         OpAnd:           alu_res = a_dat & b_dat;
         OpOr:            alu_res = a_dat | b_dat;
         OpAdd: begin
            alu_res = sum;
            alu_ovf = (a_dat[WIDTH-1] == b_dat[WIDTH-1]) && (sum[WIDTH-1] != a_dat[WIDTH-1]);
         end
         OpSub: begin
            alu_res = diff;
            alu_ovf = (a_dat[WIDTH-1] != b_dat[WIDTH-1]) && (diff[WIDTH-1] != a_dat[WIDTH-1]);
         end
         OpAddu, OpAddiu: alu_res = sum;
         OpSubu:          alu_res = diff;
         OpSll, OpSllv:   alu_res = b_dat << shamt;
         OpSrl, OpSrlv:   alu_res = b_dat >> shamt;
         OpSra, OpSrav:   alu_res = $signed(b_dat) >>> shamt;
         OpSlt, OpSlti:   alu_res = {{(WIDTH-1){1'b0}}, slt_s};
         OpSltu, OpSltiu: alu_res = {{(WIDTH-1){1'b0}}, slt_u};
         OpNor:           alu_res = ~(a_dat | b_dat);
         OpXor, OpXori:   alu_res = a_dat ^ b_dat;
         OpLui:           alu_res = b_dat << 16;
         OpMfhi:          alu_res = hi_q;
         OpMflo:          alu_res = lo_q;
         OpMthi, OpMtlo:  alu_res = a_dat;
         default:         alu_res = '0;
      endcase
   end

   // Operand magnitudes for the iterative datapath; signs are restored in StFix
   logic             op_signed, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   assign op_signed = (alu_op == OpMult) || (alu_op == OpDiv);
   assign a_neg     = op_signed && a_dat[WIDTH-1];
   assign b_neg     = op_signed && b_dat[WIDTH-1];
   assign a_mag     = a_neg ? -a_dat : a_dat;
   assign b_mag     = b_neg ? -b_dat : b_dat;

   // Shift-add multiply step: add multiplicand when multiplier LSB set, shift right
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_step;
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
      mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
   end

`ifdef ALU_MDU_DIV_EN
   // Restoring divide step: shift next dividend bit into remainder, trial subtract
   logic [WIDTH:0]       div_sh, div_diff;
   logic [2*WIDTH-1:0]   div_step;
   always_comb begin
      div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, opb_q};
      div_step = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   end
`endif

   // Sign correction and HI/LO values written in StFix
   logic [2*WIDTH-1:0] mul_fix;
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   always_comb begin
      mul_fix = neg_lo_q ? -acc_q : acc_q;
      fix_hi  = mul_fix[2*WIDTH-1:WIDTH];
      fix_lo  = mul_fix[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
      if (div_q) begin
         fix_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
         // Divide by zero: quotient all ones; remainder path already yields the dividend
         fix_lo = dz_q ? '1 : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      end
`endif
   end

   // Control FSM with registered result, flags, HI/LO and iterative datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         acc_q       <= '0;
         opb_q       <= '0;
         neg_lo_q    <= 1'b0;
`ifdef ALU_MDU_DIV_EN
         div_q       <= 1'b0;
         neg_hi_q    <= 1'b0;
         dz_q        <= 1'b0;
`endif
         result_q    <= '0;
         zero_q      <= 1'b1;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else begin
         out_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  case (alu_op)
                     OpMult, OpMultu: begin
                        state_q  <= StMul;
                        cnt_q    <= SHW'(WIDTH - 1);
                        acc_q    <= {{WIDTH{1'b0}}, b_mag};
                        opb_q    <= a_mag;
                        neg_lo_q <= a_neg ^ b_neg;
`ifdef ALU_MDU_DIV_EN
                        div_q    <= 1'b0;
                        neg_hi_q <= 1'b0;
                        dz_q     <= 1'b0;
`endif
                     end
`ifdef ALU_MDU_DIV_EN
                     OpDiv, OpDivu: begin
                        state_q  <= StDiv;
                        cnt_q    <= SHW'(WIDTH - 1);
                        acc_q    <= {{WIDTH{1'b0}}, a_mag};
                        opb_q    <= b_mag;
                        neg_lo_q <= a_neg ^ b_neg;
                        div_q    <= 1'b1;
                        neg_hi_q <= a_neg;
                        dz_q     <= (b_dat == '0);
                     end
`endif
                     default: begin
                        result_q    <= alu_res;
                        zero_q      <= (alu_res == '0);
                        ovf_q       <= alu_ovf;
                        out_valid_q <= 1'b1;
                        if (alu_op == OpMthi) hi_q <= a_dat;
                        if (alu_op == OpMtlo) lo_q <= a_dat;
                     end
                  endcase
               end
            end
            StMul: begin
               acc_q <= mul_step;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) state_q <= StFix;
            end
`ifdef ALU_MDU_DIV_EN
            StDiv: begin
               acc_q <= div_step;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) state_q <= StFix;
            end
`endif
            StFix: begin
               hi_q        <= fix_hi;
               lo_q        <= fix_lo;
               result_q    <= fix_lo;
               zero_q      <= (fix_lo == '0);
               ovf_q       <= 1'b0;
               out_valid_q <= 1'b1;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu at WIDTH=32.
// Divider vectors are used when ALU_MDU_DIV_EN is defined, otherwise the
// single-cycle DIV fallback is exercised.
module tb_alu_mdu;

   localparam int unsigned W = 32;

   localparam logic [4:0] OpAdd  = 5'd2;
   localparam logic [4:0] OpSll  = 5'd3;
   localparam logic [4:0] OpSra  = 5'd5;
   localparam logic [4:0] OpSub  = 5'd6;
   localparam logic [4:0] OpSlt  = 5'd7;
   localparam logic [4:0] OpNor  = 5'd8;
   localparam logic [4:0] OpAddu = 5'd10;
   localparam logic [4:0] OpSltu = 5'd11;
   localparam logic [4:0] OpLui  = 5'd18;
   localparam logic [4:0] OpMult = 5'd22;
   localparam logic [4:0] OpMulu = 5'd23;
   localparam logic [4:0] OpDiv  = 5'd24;
   localparam logic [4:0] OpDivu = 5'd25;
   localparam logic [4:0] OpMfhi = 5'd26;
   localparam logic [4:0] OpMflo = 5'd27;
   localparam logic [4:0] OpMthi = 5'd28;
   localparam logic [4:0] OpMtlo = 5'd29;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [4:0]   alu_op = '0;
   logic [W-1:0] a_dat = '0;
   logic [W-1:0] b_dat = '0;
   logic         out_valid;
   logic [W-1:0] result;
   logic         zero;
   logic         overflow;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int errors = 0;
   int checks = 0;
   int lat;
   int busy;
   int pulses;

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .a_dat     (a_dat),
      .b_dat     (b_dat),
      .out_valid (out_valid),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .hi        (hi),
      .lo        (lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request and wait (bounded) for out_valid; lat = cycles after acceptance
   task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int l);
      @(negedge clk);
      alu_op   = op;
      a_dat    = a;
      b_dat    = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      l = 1;
      while (!out_valid && l < 100) begin
         @(negedge clk);
         l++;
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 1);
      chk("rst_ovf", overflow, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_ready", in_ready, 1);
      rst_n = 1'b1;

      // ADD with signed overflow
      run_op(OpAdd, 32'h7FFF_FFFF, 32'h1, lat);
      chk("add_lat", lat, 1);
      chk("add_res", result, 64'h8000_0000);
      chk("add_ovf", overflow, 1);
      chk("add_zero", zero, 0);
      @(negedge clk);
      chk("pulse_drop", out_valid, 0);
      chk("res_hold", result, 64'h8000_0000);

      run_op(OpAddu, 32'h7FFF_FFFF, 32'h1, lat);
      chk("addu_res", result, 64'h8000_0000);
      chk("addu_ovf", overflow, 0);

      run_op(OpSra, 32'h4, 32'hF000_0000, lat);
      chk("sra_res", result, 64'hFF00_0000);
      run_op(OpSll, 32'h24, 32'h1, lat);
      chk("sll_res", result, 64'h10);
      run_op(OpSub, 32'd5, 32'd5, lat);
      chk("sub_res", result, 0);
      chk("sub_zero", zero, 1);
      chk("sub_ovf", overflow, 0);
      run_op(OpSub, 32'h8000_0000, 32'h1, lat);
      chk("subov_res", result, 64'h7FFF_FFFF);
      chk("subov_ovf", overflow, 1);
      run_op(OpSlt, 32'hFFFF_FFFF, 32'h1, lat);
      chk("slt_res", result, 1);
      run_op(OpSltu, 32'hFFFF_FFFF, 32'h1, lat);
      chk("sltu_res", result, 0);
      run_op(OpLui, 32'h0, 32'h1234, lat);
      chk("lui_res", result, 64'h1234_0000);
      run_op(OpNor, 32'h0, 32'h0, lat);
      chk("nor_res", result, 64'hFFFF_FFFF);
      run_op(5'd30, 32'h55, 32'h66, lat);
      chk("op30_res", result, 0);
      chk("op30_zero", zero, 1);

      // HI/LO moves
      run_op(OpMthi, 32'h1234, 32'h0, lat);
      chk("mthi_res", result, 64'h1234);
      chk("mthi_hi", hi, 64'h1234);
      run_op(OpMfhi, 32'h0, 32'h0, lat);
      chk("mfhi_res", result, 64'h1234);
      run_op(OpMtlo, 32'h55, 32'h0, lat);
      chk("mtlo_lo", lo, 64'h55);
      run_op(OpMflo, 32'h0, 32'h0, lat);
      chk("mflo_res", result, 64'h55);

      // MULT -2*3 with a request held while busy
      @(negedge clk);
      alu_op   = OpMult;
      a_dat    = 32'hFFFF_FFFE;
      b_dat    = 32'd3;
      in_valid = 1'b1;
      @(negedge clk);
      alu_op = OpMfhi;
      a_dat  = '0;
      b_dat  = '0;
      lat    = 1;
      busy   = 0;
      while (!out_valid && lat < 100) begin
         if (!in_ready) busy++;
         @(negedge clk);
         lat++;
      end
      chk("mult_lat", lat, 34);
      chk("mult_busy", busy, 33);
      chk("mult_ready", in_ready, 1);
      chk("mult_hi", hi, 64'hFFFF_FFFF);
      chk("mult_lo", lo, 64'hFFFF_FFFA);
      chk("mult_res", result, 64'hFFFF_FFFA);
      @(negedge clk);
      in_valid = 1'b0;
      chk("held_valid", out_valid, 1);
      chk("held_mfhi", result, 64'hFFFF_FFFF);

      run_op(OpMulu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      chk("multu_lat", lat, 34);
      chk("multu_hi", hi, 64'hFFFF_FFFE);
      chk("multu_lo", lo, 64'h1);
      run_op(OpMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      chk("mult_nn_hi", hi, 0);
      chk("mult_nn_lo", lo, 1);
      run_op(OpMflo, 32'h0, 32'h0, lat);
      chk("mflo_after", result, 1);

`ifdef ALU_MDU_DIV_EN
      run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, lat);
      chk("div_lat", lat, 34);
      chk("div_lo", lo, 64'hFFFF_FFFD);
      chk("div_hi", hi, 64'hFFFF_FFFF);
      run_op(OpDiv, 32'd7, 32'hFFFF_FFFE, lat);
      chk("div2_lo", lo, 64'hFFFF_FFFD);
      chk("div2_hi", hi, 64'h1);
      run_op(OpDivu, 32'd7, 32'd0, lat);
      chk("divz_lat", lat, 34);
      chk("divz_lo", lo, 64'hFFFF_FFFF);
      chk("divz_hi", hi, 64'h7);
      run_op(OpDiv, 32'hFFFF_FFFB, 32'd0, lat);
      chk("sdivz_lo", lo, 64'hFFFF_FFFF);
      chk("sdivz_hi", hi, 64'hFFFF_FFFB);
      run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      chk("divmin_lo", lo, 64'h8000_0000);
      chk("divmin_hi", hi, 0);
      run_op(OpDivu, 32'd100, 32'd7, lat);
      chk("divu_lo", lo, 64'd14);
      chk("divu_hi", hi, 64'd2);
`else
      run_op(OpMthi, 32'hAAAA, 32'h0, lat);
      run_op(OpMtlo, 32'h5555, 32'h0, lat);
      run_op(OpDiv, 32'd8, 32'd2, lat);
      chk("nodiv_lat", lat, 1);
      chk("nodiv_res", result, 0);
      chk("nodiv_zero", zero, 1);
      chk("nodiv_hi", hi, 64'hAAAA);
      chk("nodiv_lo", lo, 64'h5555);
      run_op(OpDivu, 32'd9, 32'd3, lat);
      chk("nodivu_lat", lat, 1);
      chk("nodivu_lo", lo, 64'h5555);
`endif

      // Reset 10 cycles into a MULT
      @(negedge clk);
      alu_op   = OpMult;
      a_dat    = 32'd3;
      b_dat    = 32'd5;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid_busy", in_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("abort_ready", in_ready, 1);
      chk("abort_hi", hi, 0);
      chk("abort_lo", lo, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_result", result, 0);
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      chk("abort_pulses", pulses, 0);
      chk("abort_lo_end", lo, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
